// File: rtl/rc4_phase_scheduler.sv
// rtl/rc4_phase_scheduler.sv - RC4 key-search phase sequencer and S-memory port owner
//
// Purpose:
//   Steps a candidate key through a programmed inclusive range. For each key
//   it runs the init, shuffle and decrypt phases in order. It owns the single
//   S-memory port and muxes it to whichever phase is active. The search ends
//   when decrypt reports valid plaintext, when the range is exhausted, when a
//   phase watchdog fires, or when stop is raised.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   start, stop            begin a search from key_lo / synchronous abort
//   key_lo, key_hi         inclusive key range, sampled on start
//   key                    current candidate key
//   *_start / *_finish     per-phase start pulses and completion inputs
//   dec_valid              plaintext check result, qualified by dec_finish
//   *_addr/_data/_wen      per-phase S-memory requests
//   s_addr/s_data/s_wen    muxed S-memory port
//   memory_sel             port owner: 00 none, 01 init, 10 shuffle, 11 decrypt
//   busy, done             search active / one-cycle end-of-search pulse
//   found, timeout         result flags, held until the next start

module rc4_phase_scheduler #(
   parameter int KEY_W       = 24,
   parameter int TIMEOUT_CYC = 4096,
   parameter int TO_W        = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [KEY_W-1:0] key_lo,
   input  logic [KEY_W-1:0] key_hi,
   output logic [KEY_W-1:0] key,
   output logic             init_start,
   output logic             shuf_start,
   output logic             dec_start,
   input  logic             init_finish,
   input  logic             shuf_finish,
   input  logic             dec_finish,
   input  logic             dec_valid,
   input  logic [7:0]       init_addr,
   input  logic [7:0]       init_data,
   input  logic             init_wen,
   input  logic [7:0]       shuf_addr,
   input  logic [7:0]       shuf_data,
   input  logic             shuf_wen,
   input  logic [7:0]       dec_addr,
   input  logic [7:0]       dec_data,
   input  logic             dec_wen,
   output logic [7:0]       s_addr,
   output logic [7:0]       s_data,
   output logic             s_wen,
   output logic [1:0]       memory_sel,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             timeout
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] INIT_GO   = 4'd1;
   localparam logic [3:0] INIT_WAIT = 4'd2;
   localparam logic [3:0] SHUF_GO   = 4'd3;
   localparam logic [3:0] SHUF_WAIT = 4'd4;
   localparam logic [3:0] DEC_GO    = 4'd5;
   localparam logic [3:0] DEC_WAIT  = 4'd6;
   localparam logic [3:0] CHECK     = 4'd7;
   localparam logic [3:0] DONE      = 4'd8;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_INIT = 2'b01;
   localparam logic [1:0] SEL_SHUF = 2'b10;
   localparam logic [1:0] SEL_DEC  = 2'b11;

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [3:0]       state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [KEY_W-1:0] hi_q, hi_d;
   logic [1:0]       sel_q, sel_d;
   logic             found_q, found_d;
   logic             timeout_q, timeout_d;
   logic             valid_q, valid_d;
   logic [TO_W-1:0]  wd_q, wd_d;

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      hi_d      = hi_q;
      sel_d     = sel_q;
      found_d   = found_q;
      timeout_d = timeout_q;
      valid_d   = valid_q;
      wd_d      = wd_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               hi_d      = key_hi;
               key_d     = key_lo;
               found_d   = 1'b0;
               timeout_d = 1'b0;
               state_d   = INIT_GO;
            end
         end
         INIT_GO: begin
            sel_d   = SEL_INIT;
            wd_d    = '0;
            state_d = INIT_WAIT;
         end
         INIT_WAIT: begin
            // A finish on the watchdog's last cycle still wins.
            if (init_finish) begin
               state_d = SHUF_GO;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         SHUF_GO: begin
            sel_d   = SEL_SHUF;
            wd_d    = '0;
            state_d = SHUF_WAIT;
         end
         SHUF_WAIT: begin
            if (shuf_finish) begin
               state_d = DEC_GO;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         DEC_GO: begin
            sel_d   = SEL_DEC;
            wd_d    = '0;
            valid_d = 1'b0;
            state_d = DEC_WAIT;
         end
         DEC_WAIT: begin
            if (dec_finish) begin
               valid_d = dec_valid;
               state_d = CHECK;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         CHECK: begin
            if (valid_q) begin
               found_d = 1'b1;
               state_d = DONE;
            end else if (key_q == hi_q) begin
               state_d = DONE;
            end else begin
               // Natural width wrap lets key_hi < key_lo sweep through zero.
               key_d   = key_q + 1'b1;
               state_d = INIT_GO;
            end
         end
         DONE: begin
            sel_d   = SEL_NONE;
            state_d = IDLE;
         end
         default: begin
            sel_d   = SEL_NONE;
            state_d = IDLE;
         end
      endcase

      // Abort overrides everything decided above, including CHECK and timeout.
      if (stop && (state_q != IDLE)) begin
         state_d   = IDLE;
         sel_d     = SEL_NONE;
         found_d   = 1'b0;
         timeout_d = timeout_q;
         key_d     = key_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         key_q     <= '0;
         hi_q      <= '0;
         sel_q     <= SEL_NONE;
         found_q   <= 1'b0;
         timeout_q <= 1'b0;
         valid_q   <= 1'b0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         hi_q      <= hi_d;
         sel_q     <= sel_d;
         found_q   <= found_d;
         timeout_q <= timeout_d;
         valid_q   <= valid_d;
         wd_q      <= wd_d;
      end
   end

   // Port mux keyed off the registered owner so a non-owner wen never leaks.
   always_comb begin
      s_addr = 8'h00;
      s_data = 8'h00;
      s_wen  = 1'b0;
      case (sel_q)
         SEL_INIT: begin
            s_addr = init_addr;
            s_data = init_data;
            s_wen  = init_wen;
         end
         SEL_SHUF: begin
            s_addr = shuf_addr;
            s_data = shuf_data;
            s_wen  = shuf_wen;
         end
         SEL_DEC: begin
            s_addr = dec_addr;
            s_data = dec_data;
            s_wen  = dec_wen;
         end
         default: begin
            s_addr = 8'h00;
            s_data = 8'h00;
            s_wen  = 1'b0;
         end
      endcase
   end

   assign key        = key_q;
   assign memory_sel = sel_q;
   assign init_start = (state_q == INIT_GO);
   assign shuf_start = (state_q == SHUF_GO);
   assign dec_start  = (state_q == DEC_GO);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign found      = found_q;
   assign timeout    = timeout_q;

endmodule

// File: doc/rc4_phase_scheduler.md
Name: rc4_phase_scheduler

Overview:
Top-level sequencer for the RC4 key-search datapath. Runs the three S-memory phases in order for each candidate key: init (S[i]=i), shuffle (key schedule), then decrypt via mem_decrypt. It owns the single S-memory port, muxing it to the active phase, and steps the key through a programmed range until decrypt reports a valid plaintext or the range is exhausted.

Parameters:
KEY_W, 24, candidate key width in bits
TIMEOUT_CYC, 4096, max cycles any phase may stay busy before abort
TO_W, 13, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins a search from key_lo
stop  in  1  synchronous abort; returns to IDLE
key_lo  in  KEY_W  first key, sampled on start
key_hi  in  KEY_W  last key inclusive, sampled on start
key  out  KEY_W  current candidate key
init_start / shuf_start / dec_start  out  1 each  one-cycle phase start pulses
init_finish / shuf_finish / dec_finish  in  1 each  phase completion, sampled only in that phase's WAIT state
dec_valid  in  1  plaintext check result, qualified by dec_finish
init_addr, init_data / shuf_addr, shuf_data / dec_addr, dec_data  in  8 each  phase S-memory requests
init_wen / shuf_wen / dec_wen  in  1 each  phase write enables
s_addr  out  8  S-memory address
s_data  out  8  S-memory write data
s_wen  out  1  S-memory write enable
memory_sel  out  2  owner: 00 none, 01 init, 10 shuffle, 11 decrypt
busy  out  1  high from the cycle after start until DONE
done  out  1  one-cycle pulse at search end
found  out  1  valid key located; held until next start
timeout  out  1  phase watchdog fired; held until next start

Behaviour:
- Reset (reset=0, async): state=IDLE, key=0, memory_sel=00, all *_start=0, busy=0, done=0, found=0, timeout=0, internal key_lo/key_hi registers=0, watchdog=0.
- States: IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, CHECK, DONE.
- IDLE: start=1 -> latch key_lo/key_hi, key<=key_lo, clear found/timeout, go INIT_GO. Start is ignored in every other state.
- X_GO: assert X_start for exactly one cycle, set memory_sel to the phase code, clear watchdog, go X_WAIT.
- X_WAIT: X_finish=1 -> next GO state (INIT->SHUF_GO, SHUF->DEC_GO, DEC->CHECK). On dec_finish, latch dec_valid. Finish signals of non-active phases are ignored.
- CHECK: latched valid=1 -> found<=1, DONE. Else key==key_hi -> DONE with found=0. Else key<=key+1, INIT_GO.
- Key wrap: key_hi<key_lo is legal. Key increments modulo 2^KEY_W until it equals key_hi. key_lo==key_hi tests exactly one key.
- DONE: done=1 for one cycle, memory_sel<=00, go IDLE. Key, found and timeout hold their values.
- Watchdog: counts every cycle in any WAIT state. When it reaches TIMEOUT_CYC-1 without a finish, set timeout<=1, go DONE (done pulses, found=0). A finish arriving on that same cycle wins; no timeout is flagged.
- stop=1 in any non-IDLE state: next state IDLE, memory_sel=00, busy=0, no done pulse, found=0. stop has priority over finish, timeout and CHECK. stop in IDLE has no effect.
- Memory mux, combinational from the registered memory_sel: 01/10/11 route the matching phase's addr/data/wen to s_*. 00 gives s_addr=0, s_data=0, s_wen=0. A non-owner wen never reaches s_wen.
- busy = state not IDLE. With instantaneous finishes, the minimum per-key loop is 7 cycles (INIT_GO..CHECK).

Test Plan:
- Single key: key_lo=key_hi=0x000249, all finishes 3 cycles after start, dec_valid=1 -> one each of init/shuf/dec start pulses in order, done pulse, found=1, key=0x000249, memory_sel back to 00.
- Range sweep: key_lo=0x10, key_hi=0x13, dec_valid=1 only for key 0x12 -> exactly 3 init_start pulses, done with found=1, key=0x12.
- Exhaust with wrap: key_lo=0xFFFFFE, key_hi=0x000001, dec_valid=0 always -> keys FFFFFE, FFFFFF, 000000, 000001 tried (4 passes), done, found=0.
- Watchdog: TIMEOUT_CYC=16, shuf_finish never asserted -> done 16 cycles after SHUF_WAIT entry, timeout=1, found=0, no dec_start.
- Mux isolation: during SHUF_WAIT drive init_wen=1, init_addr=0x55, shuf_addr=0xAA, shuf_wen=0 -> s_addr=0xAA, s_wen=0, memory_sel=10.
- Abort: stop during DEC_WAIT -> IDLE next cycle, busy=0, no done pulse. Reset low mid-INIT_WAIT -> all outputs clear immediately.
